// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives operands and start; the slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// one bit per clock, with start/busy/done handshake and signed-overflow flag.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             carry_out_q;
  logic             overflow_q;
  logic             bit_s;
  logic             carry_nxt;
  logic             last_bit;
  logic             accept;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = majority(a_sr[0], b_sr[0], carry);
  assign last_bit  = (cnt == LAST_BIT);
  assign accept    = (state_q != RUN) && bus.start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.start ? RUN : IDLE;
      RUN:        if (last_bit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      s_sr        <= '0;
      sum_q       <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction runs as a + ~b + ~borrow_in through the same adder cell.
        a_sr  <= bus.a;
        b_sr  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub ? ~bus.carry_in : bus.carry_in;
        s_sr  <= '0;
        cnt   <= '0;
      end else if (state_q == RUN) begin
        a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
        s_sr  <= {bit_s, s_sr[WIDTH-1:1]};
        carry <= carry_nxt;
        cnt   <= cnt + 1'b1;
        // On the MSB, 'carry' is still the carry into the MSB, so
        // carry-in ^ carry-out of the top bit gives signed overflow.
        if (last_bit) begin
          sum_q       <= {bit_s, s_sr[WIDTH-1:1]};
          carry_out_q <= carry_nxt;
          overflow_q  <= carry ^ carry_nxt;
        end
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and model-based bench for serial_adder at WIDTH 8, 4, 2 and 32.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(4))  if4 ();
  serial_adder_if #(.WIDTH(2))  if2 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
  serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));
  serial_adder #(.WIDTH(2))  dut2  (.clk(clk), .reset(reset), .bus(if2));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural reference: integer a +/- b +/- cin at width w.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input logic cin,
                                output logic [63:0] s, output logic co, output logic ov);
    longint mask, ua, ub, sa, sb, ci, t, sr, lo, hi;
    mask = (64'sd1 <<< w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
    sb   = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
    ci   = cin ? 64'sd1 : 64'sd0;
    lo   = -(64'sd1 <<< (w - 1));
    hi   = (64'sd1 <<< (w - 1)) - 1;
    if (!sub) begin
      t  = ua + ub + ci;
      sr = sa + sb + ci;
      co = (t > mask);
    end else begin
      t  = ua - ub - ci;
      sr = sa - sb - ci;
      co = (t >= 0);
    end
    s  = 64'(t & mask);
    ov = (sr < lo) || (sr > hi);
  endfunction

  // Present an op at a negedge, wait for done; operands are scrambled while busy.
  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                     input logic hold, output logic [7:0] s, output logic co, output logic ov,
                     output int nbusy, output int ncyc);
    if8.a = a; if8.b = b; if8.sub = sub; if8.carry_in = cin; if8.start = 1'b1;
    nbusy = 0; ncyc = 0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ncyc++;
      if (if8.done) break;
      if (if8.busy) nbusy++;
      if8.start = hold; if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.sub = 1'($urandom); if8.carry_in = 1'($urandom);
    end
    if (!if8.done) check("w8 timeout", 64'd0, 64'd1);
    s = if8.sum; co = if8.carry_out; ov = if8.overflow;
  endtask

  task automatic do4(input logic [3:0] a, input logic [3:0] b, input logic sub, input logic cin,
                     output logic [3:0] s, output logic co, output logic ov);
    if4.a = a; if4.b = b; if4.sub = sub; if4.carry_in = cin; if4.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if4.done) break;
      if4.a = 4'($urandom); if4.b = 4'($urandom); if4.sub = 1'($urandom); if4.carry_in = 1'($urandom);
    end
    if (!if4.done) check("w4 timeout", 64'd0, 64'd1);
    s = if4.sum; co = if4.carry_out; ov = if4.overflow;
  endtask

  task automatic do2(input logic [1:0] a, input logic [1:0] b, input logic sub, input logic cin,
                     output logic [1:0] s, output logic co, output logic ov);
    if2.a = a; if2.b = b; if2.sub = sub; if2.carry_in = cin; if2.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if2.done) break;
      if2.a = 2'($urandom); if2.b = 2'($urandom); if2.sub = 1'($urandom); if2.carry_in = 1'($urandom);
    end
    if (!if2.done) check("w2 timeout", 64'd0, 64'd1);
    s = if2.sum; co = if2.carry_out; ov = if2.overflow;
  endtask

  task automatic do32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                      output logic [31:0] s, output logic co, output logic ov);
    if32.a = a; if32.b = b; if32.sub = sub; if32.carry_in = cin; if32.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if32.done) break;
      if32.a = $urandom; if32.b = $urandom; if32.sub = 1'($urandom); if32.carry_in = 1'($urandom);
    end
    if (!if32.done) check("w32 timeout", 64'd0, 64'd1);
    s = if32.sum; co = if32.carry_out; ov = if32.overflow;
  endtask

  initial begin
    logic [7:0]  s8;
    logic [3:0]  s4;
    logic [1:0]  s2;
    logic [31:0] s32;
    logic [63:0] es;
    logic        co, ov, eco, eov, sb, cb;
    logic [31:0] ra, rb;
    int          nb, nc, seen;

    if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0; if8.carry_in = 1'b0;
    if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0; if4.carry_in = 1'b0;
    if2.start = 1'b0; if2.sub = 1'b0; if2.a = '0; if2.b = '0; if2.carry_in = 1'b0;
    if32.start = 1'b0; if32.sub = 1'b0; if32.a = '0; if32.b = '0; if32.carry_in = 1'b0;

    // Reset, with a start held during reset that must be ignored.
    reset = 1'b1;
    if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 64'(if8.busy), 64'd0);
    check("rst done", 64'(if8.done), 64'd0);
    check("rst sum", 64'(if8.sum), 64'd0);
    check("rst carry_out", 64'(if8.carry_out), 64'd0);
    check("rst overflow", 64'(if8.overflow), 64'd0);
    if8.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", 64'(if8.busy), 64'd0);

    // 0x5A + 0x33 = 0x8D, signed overflow.
    do8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, s8, co, ov, nb, nc);
    check("5a+33 sum", 64'(s8), 64'h8D);
    check("5a+33 co", 64'(co), 64'd0);
    check("5a+33 ov", 64'(ov), 64'd1);
    check("5a+33 busy cycles", 64'(nb), 64'd8);
    check("5a+33 latency", 64'(nc), 64'd9);
    @(negedge clk);
    check("done one cycle", 64'(if8.done), 64'd0);
    check("sum held", 64'(if8.sum), 64'h8D);

    // 0xFF + 0x01 + 1, then back-to-back 0x10 - 0x20.
    do8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, s8, co, ov, nb, nc);
    check("ff+01+1 sum", 64'(s8), 64'h01);
    check("ff+01+1 co", 64'(co), 64'd1);
    check("ff+01+1 ov", 64'(ov), 64'd0);
    do8(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, s8, co, ov, nb, nc);
    check("10-20 sum", 64'(s8), 64'hF0);
    check("10-20 co", 64'(co), 64'd0);
    check("10-20 ov", 64'(ov), 64'd0);
    check("b2b latency", 64'(nc), 64'd9);

    // 0x80 - 0x01, then 0x05 - 0x03 - borrow.
    do8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, s8, co, ov, nb, nc);
    check("80-01 sum", 64'(s8), 64'h7F);
    check("80-01 co", 64'(co), 64'd1);
    check("80-01 ov", 64'(ov), 64'd1);
    do8(8'h05, 8'h03, 1'b1, 1'b1, 1'b0, s8, co, ov, nb, nc);
    check("05-03-1 sum", 64'(s8), 64'h01);
    check("05-03-1 co", 64'(co), 64'd1);
    check("05-03-1 ov", 64'(ov), 64'd0);

    // Start held high throughout, operands changing every cycle.
    do8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, s8, co, ov, nb, nc);
    check("hold 12+34 sum", 64'(s8), 64'h46);
    check("hold 12+34 latency", 64'(nc), 64'd9);
    do8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, s8, co, ov, nb, nc);
    check("hold 7f+01 sum", 64'(s8), 64'h80);
    check("hold 7f+01 ov", 64'(ov), 64'd1);
    check("hold 7f+01 latency", 64'(nc), 64'd9);
    do8(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, s8, co, ov, nb, nc);
    check("hold 00-01 sum", 64'(s8), 64'hFF);
    check("hold 00-01 co", 64'(co), 64'd0);
    check("hold 00-01 busy cycles", 64'(nb), 64'd8);
    if8.start = 1'b0;
    @(negedge clk);

    // Abort an operation with reset three cycles in.
    do8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, s8, co, ov, nb, nc);
    check("pre-abort sum", 64'(s8), 64'h8D);
    if8.a = 8'h44; if8.b = 8'h22; if8.sub = 1'b0; if8.carry_in = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(if8.busy), 64'd0);
    check("abort sum", 64'(if8.sum), 64'd0);
    check("abort carry_out", 64'(if8.carry_out), 64'd0);
    check("abort overflow", 64'(if8.overflow), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done) seen++;
      @(negedge clk);
    end
    check("abort no done", 64'(seen), 64'd0);
    do8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, s8, co, ov, nb, nc);
    check("post-abort 01+01", 64'(s8), 64'h02);
    if8.start = 1'b0;
    @(negedge clk);

    // WIDTH=4 exhaustive, back-to-back.
    for (int k = 0; k < 1024; k++) begin
      do4(k[3:0], k[7:4], k[9], k[8], s4, co, ov);
      model(4, 64'(k[3:0]), 64'(k[7:4]), k[9], k[8], es, eco, eov);
      check($sformatf("w4 sum k=%0d", k), 64'(s4), es);
      check($sformatf("w4 co k=%0d", k), 64'(co), 64'(eco));
      check($sformatf("w4 ov k=%0d", k), 64'(ov), 64'(eov));
    end
    if4.start = 1'b0;

    // WIDTH=2 and WIDTH=32 random.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom; rb = $urandom; sb = 1'($urandom); cb = 1'($urandom);
      do2(ra[1:0], rb[1:0], sb, cb, s2, co, ov);
      model(2, 64'(ra[1:0]), 64'(rb[1:0]), sb, cb, es, eco, eov);
      check("w2 sum", 64'(s2), es);
      check("w2 co", 64'(co), 64'(eco));
      check("w2 ov", 64'(ov), 64'(eov));
    end
    if2.start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      ra = $urandom; rb = $urandom; sb = 1'($urandom); cb = 1'($urandom);
      do32(ra, rb, sb, cb, s32, co, ov);
      model(32, 64'(ra), 64'(rb), sb, cb, es, eco, eov);
      check("w32 sum", 64'(s32), es);
      check("w32 co", 64'(co), 64'(eco));
      check("w32 ov", 64'(ov), 64'(eov));
    end
    if32.start = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
